seq_detect_mealy_param: RTL and testbench



---
 rtl/seq_detect_mealy_param.sv | 113 +++++++++++
 tb/tb_seq_detect_mealy_param.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_mealy_param.sv
// seq_detect_mealy_param
// Mealy serial pattern detector. It watches the accepted bits of x (cycles with
// valid=1) for a WIDTH-bit PATTERN, where the MSB is the first bit received.
// z rises combinationally in the same cycle as the final matching bit.
// OVERLAP=1 keeps the tail of a match as history for the next match.
// OVERLAP=0 discards all history after a match.
// Optional feature: define SEQDET_COUNT_EN to build a saturating match counter
// on count. Without it, count is tied to zero and z behaves identically.
//
// Handshake: valid qualifies x for one cycle. There is no back-pressure.
// z is meaningful only while valid=1 and must be sampled in that same cycle.
// clear flushes the history on the next edge and overrides valid.
module seq_detect_mealy_param #(
    parameter int                 WIDTH   = 4,
    parameter logic [WIDTH-1:0]   PATTERN = 4'b1001,
    parameter int                 OVERLAP = 1,
    parameter int                 CNT_W   = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             x,
    input  logic             valid,
    input  logic             clear,
    output logic             z,
    output logic [CNT_W-1:0] count
);

    localparam int                FILL_W   = $clog2(WIDTH);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(WIDTH - 1);

    // Sequence state, decoded from the fill level. Checkers can bind to seq_state.
    localparam logic [1:0] ST_EMPTY   = 2'd0;
    localparam logic [1:0] ST_FILLING = 2'd1;
    localparam logic [1:0] ST_ARMED   = 2'd2;

    logic [WIDTH-2:0]  hist_q, hist_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [1:0]        seq_state;
    logic [WIDTH-1:0]  window;
    logic              match;

    // History plus the bit currently on x. This forms both the candidate
    // pattern and the shifted history. Slicing avoids a negative index when WIDTH=2.
    assign window = {hist_q, x};

    // Decode the sequence state and evaluate the Mealy match for this cycle.
    always_comb begin
        seq_state = ST_FILLING;
        if (fill_q == '0) begin
            seq_state = ST_EMPTY;
        end else if (fill_q == FILL_MAX) begin
            seq_state = ST_ARMED;
        end
        match = valid & ~clear & (seq_state == ST_ARMED) & (window == PATTERN);
    end

    assign z = match;

    // Next-state logic, in priority order: clear, hold, shift, non-overlap flush.
    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        if (clear) begin
            hist_d = '0;
            fill_d = '0;
        end else if (valid) begin
            if (match && (OVERLAP == 0)) begin
                hist_d = '0;
                fill_d = '0;
            end else begin
                hist_d = window[WIDTH-2:0];
                fill_d = (fill_q == FILL_MAX) ? fill_q : fill_q + FILL_W'(1);
            end
        end
    end

    // History and fill registers. Reset discards any partial match.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hist_q <= '0;
            fill_q <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end

`ifdef SEQDET_COUNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Saturating incrementer. The counter holds once it reaches all ones.
    always_comb begin
        cnt_d = cnt_q;
        if (match && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Match counter register. clear does not touch it; only reset does.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;
`else
    assign count = '0;
`endif

endmodule

// File: tb/tb_seq_detect_mealy_param.sv
// Testbench for seq_detect_mealy_param.
// Two instances share one stimulus stream: one with OVERLAP=1 and one with OVERLAP=0.
// Each driven cycle pushes hand-computed z and count values into exp_q.
// A monitor pops exp_q on the falling edge and compares.
module tb_seq_detect_mealy_param;

`ifdef SEQDET_COUNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    localparam int W = 18;  // {z_ov, z_no, count_ov[7:0], count_no[7:0]}

    logic       clock = 1'b0;
    logic       reset;
    logic       x;
    logic       valid;
    logic       clear;
    logic       z_ov, z_no;
    logic [7:0] count_ov, count_no;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [W-1:0] exp_q[$];
    logic [7:0] exp_cnt_ov, exp_cnt_no;

    seq_detect_mealy_param #(.WIDTH(4), .PATTERN(4'b1001), .OVERLAP(1), .CNT_W(8)) u_ov (
        .clock(clock), .reset(reset), .x(x), .valid(valid), .clear(clear),
        .z(z_ov), .count(count_ov)
    );

    seq_detect_mealy_param #(.WIDTH(4), .PATTERN(4'b1001), .OVERLAP(0), .CNT_W(8)) u_no (
        .clock(clock), .reset(reset), .x(x), .valid(valid), .clear(clear),
        .z(z_no), .count(count_no)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1, "timeout");
    end

    // ---------------- compare helper ----------------
    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Apply one cycle of inputs and queue the response expected before the consuming edge.
    task automatic send(input logic bx, input logic bv, input logic bc,
                        input logic ez_ov, input logic ez_no);
        @(posedge clock);
        #1;
        x     = bx;
        valid = bv;
        clear = bc;
        exp_q.push_back({ez_ov, ez_no,
                         CNT_ON ? exp_cnt_ov : 8'd0,
                         CNT_ON ? exp_cnt_no : 8'd0});
        if (ez_ov && (exp_cnt_ov != 8'hff)) exp_cnt_ov++;
        if (ez_no && (exp_cnt_no != 8'hff)) exp_cnt_no++;
    endtask

    // Hold reset for two edges, check the reset state, then release between edges.
    task automatic do_reset();
        @(posedge clock);
        #1;
        reset = 1'b1;
        x = 1'b0; valid = 1'b0; clear = 1'b0;
        exp_cnt_ov = 8'd0;
        exp_cnt_no = 8'd0;
        #2;
        check("rst_z_ov", {7'd0, z_ov}, 8'd0);
        check("rst_z_no", {7'd0, z_no}, 8'd0);
        check("rst_cnt_ov", count_ov, 8'd0);
        check("rst_cnt_no", count_no, 8'd0);
        repeat (2) @(posedge clock);
        #3;
        reset = 1'b0;
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic [W-1:0] e;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("z_ov", {7'd0, z_ov}, {7'd0, e[17]});
                check("z_no", {7'd0, z_no}, {7'd0, e[16]});
                check("count_ov", count_ov, e[15:8]);
                check("count_no", count_no, e[7:0]);
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [10:0] t1_x, t1_zo, t1_zn;
    logic [2:0]  grp;

    initial begin
        reset = 1'b1; x = 1'b0; valid = 1'b0; clear = 1'b0;
        exp_cnt_ov = 8'd0;
        exp_cnt_no = 8'd0;

        // 1/2: stream 1001001 then 1001. OVERLAP=1 matches bits 4, 7 and 11.
        // OVERLAP=0 matches bits 4 and 11.
        do_reset();
        t1_x  = 11'b10010011001;
        t1_zo = 11'b00010010001;
        t1_zn = 11'b00010000001;
        for (int i = 10; i >= 0; i--) send(t1_x[i], 1'b1, 1'b0, t1_zo[i], t1_zn[i]);
        send(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // 3: 1001 with three valid=0 gaps between bits while x toggles.
        do_reset();
        grp = 3'b100;
        for (int i = 3; i >= 1; i--) begin
            send(grp[i-1] | (i == 3), 1'b1, 1'b0, 1'b0, 1'b0);
            for (int g = 0; g < 3; g++) send(g[0], 1'b0, 1'b0, 1'b0, 1'b0);
        end
        send(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        send(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // 4: 100, then clear with a would-be matching 1; then 1 (no match), then 1001 matches.
        do_reset();
        send(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        send(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        send(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        send(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        send(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        send(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        send(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        send(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        send(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        send(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // 5: 100, then async reset mid-cycle while a matching 1 is presented.
        do_reset();
        send(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        send(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        send(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        @(posedge clock);
        #1;
        x = 1'b1; valid = 1'b1; clear = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("async_z_ov", {7'd0, z_ov}, 8'd0);
        check("async_z_no", {7'd0, z_no}, 8'd0);
        check("async_cnt_ov", count_ov, 8'd0);
        check("async_cnt_no", count_no, 8'd0);
        repeat (2) @(posedge clock);
        #3;
        reset = 1'b0;
        exp_cnt_ov = 8'd0;
        exp_cnt_no = 8'd0;
        send(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        send(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        send(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        send(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        send(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        send(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // 6: 1001 then 299 x 001. OVERLAP=1 matches every group and saturates at 255.
        // OVERLAP=0 re-arms on odd groups and matches on even groups: 150 total.
        do_reset();
        send(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        send(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        send(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        send(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        for (int k = 1; k <= 299; k++) begin
            send(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            send(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            send(1'b1, 1'b1, 1'b0, 1'b1, (k % 2) == 0);
        end
        send(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        send(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // ---------------- final report ----------------
        repeat (3) @(negedge clock);
        if (exp_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain actual=%0d expected=0 entries left", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
